// File: rtl/frame_write_ctrl.sv
// Frame capture sequencer: arms on start, syncs to sof, streams pixels into the frame RAM.
// Optional crop window enabled by defining FRAME_WRITE_ROI_EN.
module frame_write_ctrl #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic [9:0]        roi_x0,
    input  logic [9:0]        roi_y0,
    input  logic [9:0]        roi_w,
    input  logic [9:0]        roi_h,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_din,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame
);

    localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e            state_q;
    logic [ColW-1:0]   col_q;
    logic [RowW-1:0]   row_q;
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic              restart;
    logic              last_pix;
    logic              wr_en;
    logic [ColW-1:0]   pos_col;
    logic [RowW-1:0]   pos_row;
    logic [ADDR_W-1:0] pos_addr;

    // A sof on the final pixel position is just the last pixel, not a restart.
    always_comb begin
        accept   = pix_valid && ((state_q == StArmed && sof) || state_q == StCapture);
        restart  = (state_q == StCapture) && sof && !(col_q == LastCol && row_q == LastRow);
        pos_col  = restart ? '0 : col_q;
        pos_row  = restart ? '0 : row_q;
        pos_addr = restart ? '0 : addr_q;
        last_pix = (pos_col == LastCol) && (pos_row == LastRow);
    end

`ifdef FRAME_WRITE_ROI_EN
    logic [9:0]  roi_x0_q, roi_y0_q, roi_w_q, roi_h_q;
    logic [10:0] col_ext, row_ext, x_end, y_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            roi_x0_q <= '0;
            roi_y0_q <= '0;
            roi_w_q  <= '0;
            roi_h_q  <= '0;
        end else if (state_q == StIdle && start) begin
            roi_x0_q <= roi_x0;
            roi_y0_q <= roi_y0;
            roi_w_q  <= roi_w;
            roi_h_q  <= roi_h;
        end
    end

    always_comb begin
        col_ext = 11'(pos_col);
        row_ext = 11'(pos_row);
        x_end   = {1'b0, roi_x0_q} + {1'b0, roi_w_q};
        y_end   = {1'b0, roi_y0_q} + {1'b0, roi_h_q};
        wr_en   = (col_ext >= {1'b0, roi_x0_q}) && (col_ext < x_end) &&
                  (row_ext >= {1'b0, roi_y0_q}) && (row_ext < y_end);
    end
`else
    logic unused_roi;
    assign unused_roi = ^{roi_x0, roi_y0, roi_w, roi_h};
    assign wr_en      = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StArmed;
                        busy        <= 1'b1;
                        short_frame <= 1'b0;
                        col_q       <= '0;
                        row_q       <= '0;
                        addr_q      <= '0;
                    end
                end
                StArmed, StCapture: begin
                    if (accept) begin
                        if (restart) short_frame <= 1'b1;
                        if (wr_en) begin
                            ram_we   <= 1'b1;
                            ram_addr <= pos_addr;
                            ram_din  <= pix_in;
                        end
                        addr_q <= pos_addr + ADDR_W'(wr_en);
                        if (pos_col == LastCol) begin
                            col_q <= '0;
                            row_q <= pos_row + RowW'(1);
                        end else begin
                            col_q <= pos_col + ColW'(1);
                            row_q <= pos_row;
                        end
                        if (last_pix) begin
                            state_q    <= StDone;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state_q <= StCapture;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Self-checking bench for frame_write_ctrl on a 4x3 frame: vector table, directed corner cases,
// and random stimulus against a raster-index reference model (FRAME_WRITE_ROI_EN aware).
module tb_frame_write_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 17;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst, start, sof, pix_valid;
    logic [PW-1:0] pix_in;
    logic [9:0]    roi_x0, roi_y0, roi_w, roi_h;
    logic          ram_we, busy, frame_done, short_frame;
    logic [AW-1:0] ram_addr;
    logic [PW-1:0] ram_din;

    always #5 clk = ~clk;

    frame_write_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .sof(sof), .pix_valid(pix_valid),
        .pix_in(pix_in), .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .busy(busy),
        .frame_done(frame_done), .short_frame(short_frame)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=armed 2=capture 3=done; k = raster index of next pixel,
    // n = pixels written so far in this frame.
    int m_mode = 0, m_k = 0, m_n = 0;
    int m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0;
    bit e_we, e_busy, e_done, e_short;
    int e_addr, e_din;

    function automatic bit in_roi(input int k);
`ifdef FRAME_WRITE_ROI_EN
        int c = k % W;
        int r = k / W;
        return (c >= m_x0) && (c < m_x0 + m_w) && (r >= m_y0) && (r < m_y0 + m_h);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_accept(input int p);
        if (in_roi(m_k)) begin
            e_we   = 1'b1;
            e_addr = m_n;
            e_din  = p;
            m_n++;
        end
        if (m_k == W * H - 1) begin
            e_done = 1'b1;
            m_mode = 3;
        end else begin
            m_k++;
            m_mode = 2;
        end
    endtask

    task automatic model(input bit r, input bit s, input bit f, input bit v, input int p);
        e_we   = 1'b0;
        e_done = 1'b0;
        if (!r) begin
            m_mode = 0; m_k = 0; m_n = 0;
            e_addr = 0; e_short = 1'b0;
        end else begin
            case (m_mode)
                0: if (s) begin
                    m_mode = 1; m_k = 0; m_n = 0; e_short = 1'b0;
                    m_x0 = int'(roi_x0); m_y0 = int'(roi_y0);
                    m_w = int'(roi_w); m_h = int'(roi_h);
                end
                1: if (v && f) model_accept(p);
                2: if (v) begin
                    if (f && m_k != W * H - 1) begin
                        e_short = 1'b1; m_k = 0; m_n = 0;
                    end
                    model_accept(p);
                end
                default: m_mode = 0;
            endcase
        end
        e_busy = (m_mode == 1) || (m_mode == 2);
    endtask

    int log_addr[$];
    int log_din[$];

    task automatic step(input bit r, input bit s, input bit f, input bit v, input int p);
        rst = r; start = s; sof = f; pix_valid = v; pix_in = PW'(p);
        model(r, s, f, v, p);
        @(posedge clk);
        #1;
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_we) chk("ram_din", ram_din, e_din);
        chk("busy", busy, e_busy);
        chk("frame_done", frame_done, e_done);
        chk("short_frame", short_frame, e_short);
        if (ram_we) begin
            log_addr.push_back(int'(ram_addr));
            log_din.push_back(int'(ram_din));
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    typedef struct {
        bit r, s, f, v;
        int p;
        bit we;
        int addr;
        bit bsy, done;
    } vec_t;

    vec_t tbl[15];
    int   seen;

    initial begin
        rst = 1'b0; start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
        roi_x0 = 10'd0; roi_y0 = 10'd0; roi_w = 10'd4; roi_h = 10'd3;

        // Vector table: reset, start, a clean back-to-back frame, then idle.
        tbl[0] = '{r:0, s:0, f:0, v:0, p:0, we:0, addr:0, bsy:0, done:0};
        tbl[1] = '{r:1, s:1, f:0, v:0, p:0, we:0, addr:0, bsy:1, done:0};
        for (int i = 0; i < 12; i++)
            tbl[2 + i] = '{r:1, s:0, f:(i == 0), v:1, p:i + 1, we:1, addr:i,
                           bsy:(i != 11), done:(i == 11)};
        tbl[14] = '{r:1, s:0, f:0, v:0, p:0, we:0, addr:11, bsy:0, done:0};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].p);
            chk("tbl_we", ram_we, tbl[i].we);
            chk("tbl_addr", ram_addr, tbl[i].addr);
            chk("tbl_busy", busy, tbl[i].bsy);
            chk("tbl_done", frame_done, tbl[i].done);
            if (tbl[i].we) chk("tbl_din", ram_din, tbl[i].p);
        end
        idle();

        // Pixels without start are ignored.
        log_addr.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, i == 0, 1'b1, i + 1);
        chk("nostart_writes", log_addr.size(), 0);
        chk("nostart_busy", busy, 0);

        // Short frame: 5 pixels, then a new sof restarts at addr 0.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 0, 1'b1, i + 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1);
        chk("short_flag", short_frame, 1);
        chk("short_restart_addr", ram_addr, 0);
        chk("short_restart_we", ram_we, 1);
        for (int i = 1; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1, i + 1);
        chk("short_done", frame_done, 1);
        chk("short_done_addr", ram_addr, 11);
        idle();
        // start in idle clears the sticky flag
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("short_cleared", short_frame, 0);

        // Gapped valid pattern 1,0,0,1: addresses stay contiguous.
        log_addr.delete();
        seen = 0;
        for (int c = 0; c < 60 && seen < 12; c++) begin
            if (c % 4 == 0 || c % 4 == 3) begin
                step(1'b1, 1'b0, seen == 0, 1'b1, seen + 1);
                seen++;
            end else begin
                idle();
            end
        end
        chk("gap_count", log_addr.size(), 12);
        for (int i = 0; i < log_addr.size(); i++) chk("gap_addr", log_addr[i], i);
        chk("gap_done", frame_done, 1);
        idle();

        // sof on the final pixel is just the last pixel.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, i == 0, 1'b1, i + 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 12);
        chk("lastsof_done", frame_done, 1);
        chk("lastsof_short", short_frame, 0);
        idle();

        // Reset mid-capture aborts immediately.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i == 0, 1'b1, i + 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 7);
        chk("rst_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_addr", ram_addr, 0);
        idle();

`ifdef FRAME_WRITE_ROI_EN
        // Crop window (1,1,2,2) keeps pixels 6,7,10,11 packed at 0..3.
        begin
            int exp_din[4] = '{6, 7, 10, 11};
            roi_x0 = 10'd1; roi_y0 = 10'd1; roi_w = 10'd2; roi_h = 10'd2;
            step(1'b1, 1'b1, 1'b0, 1'b0, 0);
            log_addr.delete();
            log_din.delete();
            for (int i = 0; i < 12; i++) step(1'b1, 1'b0, i == 0, 1'b1, i + 1);
            chk("roi_done", frame_done, 1);
            chk("roi_count", log_addr.size(), 4);
            for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
                chk("roi_addr", log_addr[i], i);
                chk("roi_din", log_din[i], exp_din[i]);
            end
            idle();
        end
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            roi_x0 = 10'($urandom_range(0, 4));
            roi_y0 = 10'($urandom_range(0, 3));
            roi_w  = 10'($urandom_range(0, 4));
            roi_h  = 10'($urandom_range(0, 3));
            step($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 4095)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
